// File: rtl/matvec_mac4_seq_pkg.sv
// Shared fixed-point types, FSM state encoding and helpers for the matvec sequencer.
package mac_pkg;

  localparam int unsigned Q_FRAC_W  = 14;  // fractional bits of the Q2.14 weights
  localparam int unsigned ACC_W_DEF = 32;

  typedef logic signed [15:0]          q2_14_t;
  typedef logic signed [15:0]          q4_12_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  localparam acc_t Q4_12_MAX = 32767;
  localparam acc_t Q4_12_MIN = -32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Address width that never collapses to zero bits for single-entry spaces.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a row accumulator into the Q4.12 range.
  function automatic q4_12_t sat_q4_12(input acc_t a);
    if (a > Q4_12_MAX) return q4_12_t'(Q4_12_MAX);
    if (a < Q4_12_MIN) return q4_12_t'(Q4_12_MIN);
    return q4_12_t'(a);
  endfunction

endpackage

// File: rtl/matvec_mac4_seq_if.sv
// Control, memory-read and result-stream signals of the matvec sequencer.
interface matvec_mac4_seq_if #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 16
) ();
  import mac_pkg::*;

  localparam int unsigned WA_W = addr_w(ROWS * (COLS / 4));
  localparam int unsigned XA_W = addr_w(COLS / 4);
  localparam int unsigned RW   = addr_w(ROWS);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [WA_W-1:0]       w_addr;
  logic [XA_W-1:0]       x_addr;
  logic [4*DATA_W-1:0]   w_data;
  logic [4*DATA_W-1:0]   x_data;
  logic                  y_valid;
  logic                  y_ready;
  logic [DATA_W-1:0]     y_data;
  logic [RW-1:0]         y_index;

  // Sequencer side: drives memory reads and the result stream.
  modport master (
    input  start, w_data, x_data, y_ready,
    output busy, done, rd_en, w_addr, x_addr, y_valid, y_data, y_index
  );

  // Environment side: memories, controller and result consumer.
  modport slave (
    output start, w_data, x_data, y_ready,
    input  busy, done, rd_en, w_addr, x_addr, y_valid, y_data, y_index
  );

endinterface

// File: rtl/matvec_mac4_seq_mac4.sv
// mac4: four Q2.14 x Q4.12 products, each shifted back to Q4.12, summed with wrap.
module mac4 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [4*DATA_W-1:0]        i_w,
  input  logic [4*DATA_W-1:0]        i_x,
  output logic signed [DATA_W-1:0]   o_sum
);
  import mac_pkg::*;

  localparam int unsigned PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] w_sum;

  // Full-width products, arithmetic shift, then truncating accumulation.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_sum = w_sum + DATA_W'((PW'($signed(i_w[i*DATA_W +: DATA_W])) *
                               PW'($signed(i_x[i*DATA_W +: DATA_W]))) >>> Q_FRAC_W);
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/matvec_mac4_seq.sv
// Row-by-row matrix-vector sequencer feeding mac4 and emitting saturated Q4.12 rows.
module matvec_mac4_seq #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  matvec_mac4_seq_if.master  bus
);
  import mac_pkg::*;

  localparam int unsigned CPR  = COLS / 4;
  localparam int unsigned WA_W = addr_w(ROWS * CPR);
  localparam int unsigned XA_W = addr_w(CPR);
  localparam int unsigned RW   = addr_w(ROWS);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_rd_en;
  logic                     r_rd_vld;
  logic                     r_y_valid;
  logic [RW-1:0]            r_row;
  logic [RW-1:0]            r_y_index;
  logic [XA_W-1:0]          r_chunk;
  logic [WA_W-1:0]          r_w_addr;
  logic [DATA_W-1:0]        r_y_data;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [DATA_W-1:0] w_mac;
  logic signed [ACC_W-1:0]  w_acc_next;

  mac4 #(.DATA_W(DATA_W)) u_mac4 (
    .i_w   (bus.w_data),
    .i_x   (bus.x_data),
    .o_sum (w_mac)
  );

  // Accumulator value including the quad arriving this cycle.
  always_comb begin
    w_acc_next = r_acc;
    if (r_rd_vld) w_acc_next = r_acc + ACC_W'(w_mac);
  end

  // Sequencer FSM, read pipeline and accumulator with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_y_valid <= 1'b0;
      r_row     <= '0;
      r_y_index <= '0;
      r_chunk   <= '0;
      r_w_addr  <= '0;
      r_y_data  <= '0;
      r_acc     <= '0;
    end else begin
      r_rd_vld <= r_rd_en;
      r_acc    <= w_acc_next;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_row    <= '0;
            r_chunk  <= '0;
            r_w_addr <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_rd_en  <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        // w_addr is kept as a running counter; it always equals row*CPR+chunk.
        ST_RUN: begin
          if (r_chunk == XA_W'(CPR - 1)) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_chunk  <= r_chunk + XA_W'(1);
            r_w_addr <= r_w_addr + WA_W'(1);
          end
        end
        // The last quad lands on this edge, so the result uses w_acc_next.
        ST_DRAIN: begin
          r_y_data  <= DATA_W'(sat_q4_12(acc_t'(w_acc_next)));
          r_y_index <= r_row;
          r_y_valid <= 1'b1;
          r_state   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (bus.y_ready) begin
            r_y_valid <= 1'b0;
            if (r_row == RW'(ROWS - 1)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_row    <= r_row + RW'(1);
              r_chunk  <= '0;
              r_w_addr <= r_w_addr + WA_W'(1);
              r_acc    <= '0;
              r_rd_en  <= 1'b1;
              r_state  <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.w_addr  = r_w_addr;
  assign bus.x_addr  = r_chunk;
  assign bus.y_valid = r_y_valid;
  assign bus.y_data  = r_y_data;
  assign bus.y_index = r_y_index;

endmodule

// File: tb/tb_matvec_mac4_seq.sv
// Directed bench for matvec_mac4_seq with a result scoreboard and memory model.
module tb_matvec_mac4_seq;
  import mac_pkg::*;

  localparam int unsigned ROWS   = 2;
  localparam int unsigned COLS   = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CPR    = COLS / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matvec_mac4_seq_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) bus ();

  matvec_mac4_seq #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4*DATA_W-1:0] w_mem [ROWS*CPR];
  logic [4*DATA_W-1:0] x_mem [CPR];

  typedef struct {
    int idx;
    int data;
  } exp_t;
  exp_t sb[$];

  int checks    = 0;
  int failures  = 0;
  int n_results = 0;
  int n_dones   = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] pack4(input int a3, input int a2, input int a1, input int a0);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Independent arithmetic model used for the random-operand row.
  function automatic int row_model(input int r);
    int acc;
    int q;
    int w;
    int x;
    logic [63:0] wq;
    logic [63:0] xq;
    acc = 0;
    for (int c = 0; c < int'(CPR); c++) begin
      wq = w_mem[r*CPR + c];
      xq = x_mem[c];
      q  = 0;
      for (int e = 0; e < 4; e++) begin
        w = int'($signed(wq[e*16 +: 16]));
        x = int'($signed(xq[e*16 +: 16]));
        q = q + ((w * x) >>> 14);
      end
      acc = acc + int'(shortint'(q));
    end
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return acc;
  endfunction

  task automatic fill(input logic [63:0] wq, input logic [63:0] xq);
    for (int i = 0; i < int'(ROWS*CPR); i++) w_mem[i] = wq;
    for (int i = 0; i < int'(CPR); i++) x_mem[i] = xq;
  endtask

  task automatic push2(input int d0, input int d1);
    exp_t e;
    e.idx = 0; e.data = d0; sb.push_back(e);
    e.idx = 1; e.data = d1; sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Steps until done is seen; returns the step count or -1 on timeout.
  task automatic wait_done(output int done_at);
    done_at = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    bus.busy,    0);
    chk({tag, "_done"},    bus.done,    0);
    chk({tag, "_rd_en"},   bus.rd_en,   0);
    chk({tag, "_y_valid"}, bus.y_valid, 0);
    chk({tag, "_w_addr"},  bus.w_addr,  0);
    chk({tag, "_x_addr"},  bus.x_addr,  0);
    chk({tag, "_y_data"},  bus.y_data,  0);
    chk({tag, "_y_index"}, bus.y_index, 0);
  endtask

  // Memory model: quad data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.w_data <= w_mem[bus.w_addr];
      bus.x_data <= x_mem[bus.x_addr];
    end
  end

  // Scoreboard monitor on accepted results.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done === 1'b1) n_dones++;
      if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
        n_results++;
        if (sb.size() == 0) begin
          chk("unexpected_result", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("y_data",  $signed(bus.y_data), e.data);
          chk("y_index", bus.y_index,         e.idx);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int d0;
    int r0;
    logic [63:0] nom_w;
    logic [63:0] nom_x;

    nom_w = pack4(4096, -8192, 16384, 8192);
    nom_x = pack4(16384, 4096, 4096, 8192);

    bus.start   = 1'b0;
    bus.y_ready = 1'b1;
    bus.w_data  = '0;
    bus.x_data  = '0;
    fill(nom_w, nom_x);

    // Reset state
    #1;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Nominal
    push2(20480, 20480);
    d0 = n_dones; r0 = n_results;
    pulse_start();
    chk("nom_busy_rise", bus.busy,   1);
    chk("nom_rd_en",     bus.rd_en,  1);
    chk("nom_w_addr0",   bus.w_addr, 0);
    wait_done(done_at);
    chk("nom_done_latency", done_at, 8);
    chk("nom_busy_in_done", bus.busy, 1);
    step();
    chk("nom_busy_idle", bus.busy, 0);
    chk("nom_done_pulse", bus.done, 0);
    chk("nom_results", n_results - r0, 2);
    chk("nom_dones",   n_dones - d0,   1);

    // Positive saturation
    fill(pack4(16384, 16384, 16384, 16384), pack4(6144, 6144, 6144, 6144));
    push2(32767, 32767);
    pulse_start();
    wait_done(done_at);
    chk("possat_done", done_at, 8);
    step();

    // Negative saturation
    fill(pack4(16384, 16384, 16384, 16384), pack4(-6144, -6144, -6144, -6144));
    push2(-32768, -32768);
    pulse_start();
    wait_done(done_at);
    chk("negsat_done", done_at, 8);
    step();

    // Backpressure on row 0
    fill(nom_w, nom_x);
    push2(20480, 20480);
    bus.y_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (bus.y_valid === 1'b1) break;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", bus.y_valid, 1);
      chk("bp_data",  $signed(bus.y_data), 20480);
      chk("bp_index", bus.y_index, 0);
      chk("bp_rd_en", bus.rd_en,   0);
      step();
    end
    chk("bp_valid_last", bus.y_valid, 1);
    bus.y_ready = 1'b1;
    step();
    chk("bp_row1_rd_en",  bus.rd_en,   1);
    chk("bp_row1_w_addr", bus.w_addr,  2);
    chk("bp_row1_x_addr", bus.x_addr,  0);
    chk("bp_row1_valid",  bus.y_valid, 0);
    wait_done(done_at);
    chk("bp_done_seen", done_at > 0, 1);
    step();

    // Start while busy, then start in the DONE cycle
    push2(20480, 20480);
    d0 = n_dones; r0 = n_results;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (bus.rd_en === 1'b1 && bus.w_addr === 2'd2) break;
      step();
    end
    chk("sb_in_row1", bus.w_addr, 2);
    pulse_start();
    wait_done(done_at);
    chk("sb_done_seen", done_at > 0, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("b2b_ignored_busy", bus.busy, 0);
    step();
    chk("b2b_ignored_busy2", bus.busy,  0);
    chk("b2b_ignored_rd_en", bus.rd_en, 0);
    chk("sb_results", n_results - r0, 2);
    chk("sb_dones",   n_dones - d0,   1);

    // Reset mid-run of row 0
    pulse_start();
    step();
    chk("mid_in_run", bus.rd_en, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    rst = 1'b0;
    step();
    push2(20480, 20480);
    pulse_start();
    wait_done(done_at);
    chk("postrst_done", done_at, 8);
    step();

    // Random operands against the arithmetic model
    for (int i = 0; i < int'(ROWS*CPR); i++) w_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < int'(CPR); i++) x_mem[i] = {$urandom, $urandom};
    push2(row_model(0), row_model(1));
    pulse_start();
    wait_done(done_at);
    chk("rand_done", done_at, 8);
    step();
    step();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matvec_mac4_seq.md
Name: matvec_mac4_seq

Overview:
- Sequencer that computes y = W·x for a ROWS×COLS weight matrix. W is Q2.14 and x is Q4.12.
- It streams 4-element operand quads into an internal mac4 datapath, one quad per cycle, and accumulates the per-quad Q4.12 sums for each row.
- It emits one saturated Q4.12 result per row on a valid/ready stream.
- It is the operand-producer side of mac4 and sits between the weight/vector SRAMs and the LSTM gate logic.

Parameters:
- ROWS, 2, number of output rows (≥1).
- COLS, 8, vector length; must be a multiple of 4.
- DATA_W, 16, operand and result width.
- ACC_W, 32, signed row accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a matvec; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last row is accepted.
- rd_en  out  1  memory read strobe.
- w_addr  out  $clog2(ROWS*COLS/4)  weight quad address = row*(COLS/4)+chunk.
- x_addr  out  $clog2(COLS/4)  vector quad address = chunk.
- w_data  in  4*DATA_W  quad {w3,w2,w1,w0}, Q2.14, valid 1 cycle after rd_en.
- x_data  in  4*DATA_W  quad {x3,x2,x1,x0}, Q4.12, valid 1 cycle after rd_en.
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accepts.
- y_data  out  DATA_W  row result, Q4.12, saturated.
- y_index  out  $clog2(ROWS)  row number of y_data.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE; busy, done, rd_en and y_valid are 0; addresses, y_data and y_index are 0.
  - The accumulator and rd_vld are cleared.
  - Any in-flight row is discarded.
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE:
  - On start=1: row=0, chunk=0, acc=0, go to RUN.
  - start is ignored in every other state.
- RUN:
  - rd_en=1; addresses driven from row/chunk; chunk increments each cycle.
  - When chunk=COLS/4-1, go to DRAIN.
- Read pipeline:
  - rd_vld is rd_en delayed one cycle.
  - When rd_vld=1: acc += sign_extend(mac4(w_data, x_data)).
  - mac4 semantics: each product is 32-bit Q6.26, arithmetic shift right by 14, sum of the four truncated to 16 bits (wraps; no saturation inside mac4).
- DRAIN:
  - rd_en=0; absorbs the last quad; go to EMIT.
- EMIT:
  - y_valid=1, y_index=row.
  - y_data = acc clamped to [-32768, 32767].
  - y_data and y_index stay stable while y_ready=0.
  - On y_valid&&y_ready: if row=ROWS-1, go to DONE; else row++, chunk=0, acc=0, go to RUN.
- DONE:
  - done=1 for one cycle; busy remains 1 during this cycle; go to IDLE.
  - busy=0 from IDLE onward.
- Timing with y_ready tied high: per-row latency is COLS/4+2 cycles. With COLS=8 that is 2 RUN + 1 DRAIN + 1 EMIT.
- Back-to-back start: start asserted in the same cycle DONE→IDLE is ignored. A new start is accepted in IDLE on the following cycle.

Decomposition:
- Shared package mac_pkg holds:
  - typedefs q2_14_t, q4_12_t, acc_t (signed ACC_W);
  - constants Q4_12_MAX=32767 and Q4_12_MIN=-32768;
  - the state enum;
  - the saturate function.
- The existing mac4 is instantiated as the single sub-module. The sequencer contains no multiplier of its own.

Test Plan:
- Nominal, ROWS=2, COLS=8, y_ready=1:
  - Both W quads are {4096, -8192, 16384, 8192}; both x quads are {16384, 4096, 4096, 8192}.
  - Each quad sums to 2.5 (10240).
  - Expected: y_data=20480 for rows 0 and 1, y_index=0 then 1, done 8 cycles after busy rises.
- Positive saturation:
  - All w=16384 (1.0), all x=6144 (1.5); each quad gives 24576, row acc=49152.
  - Expected: y_data=32767.
- Negative saturation:
  - All w=16384, all x=-6144; row acc=-49152.
  - Expected: y_data=-32768.
- Backpressure:
  - Hold y_ready=0 for 3 cycles in EMIT of row 0.
  - Expected: y_valid stays 1, y_data=20480 and y_index=0 stable, rd_en=0, row 1 starts in the cycle after the handshake.
- Start while busy:
  - Pulse start during RUN of row 1.
  - Expected: no restart, a single done pulse, exactly 2 results.
- Reset mid-run:
  - Assert rst during RUN of row 0.
  - Expected: all outputs 0 in the same cycle without waiting for a clk edge.
  - After release, a fresh start yields row 0 = 20480, with no residue in acc.
